// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-master arbiter (processor and decrypt engine) in front of a single
//   data memory with a combinational read port. Round-robin between the two
//   masters, one access every two cycles when both are busy.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     cpu_* / eng_* inputs       req, we, address, write_data of each master
//     cpu_gnt / eng_gnt          request accepted (pulse in the ISSUE cycle)
//     cpu_done / eng_done        access complete (pulse in the RESP cycle)
//     cpu_read_data / eng_...    read result, held until that master's next done
//     cpu_err / eng_err          out-of-range access, valid with done
//     mem_write_enable           memory write strobe (ISSUE cycle only)
//     mem_address/mem_write_data latched access, held between accesses
//     mem_read_data              memory read data, combinational from address
//     busy                       arbiter is in ISSUE or RESP
module data_mem_arbiter #(
  parameter int unsigned            DATA_WIDTH = 32,
  parameter int unsigned            ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0]  MEM_LIMIT  = 'h80000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_address,
  input  logic [DATA_WIDTH-1:0] cpu_write_data,
  input  logic                  eng_req,
  input  logic                  eng_we,
  input  logic [ADDR_WIDTH-1:0] eng_address,
  input  logic [DATA_WIDTH-1:0] eng_write_data,
  output logic                  cpu_gnt,
  output logic                  cpu_done,
  output logic [DATA_WIDTH-1:0] cpu_read_data,
  output logic                  cpu_err,
  output logic                  eng_gnt,
  output logic                  eng_done,
  output logic [DATA_WIDTH-1:0] eng_read_data,
  output logic                  eng_err,
  output logic                  mem_write_enable,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_eng_q;   // 1: engine owns the current access
  logic                  last_eng_q;    // 1: engine won the last acceptance
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] cpu_rd_q;
  logic [DATA_WIDTH-1:0] eng_rd_q;

  logic any_req;
  logic win_eng;
  logic accept;
  logic in_range;

  assign any_req  = cpu_req | eng_req;
  // With both requesting, the master that did not win last time goes next.
  assign win_eng  = (cpu_req & eng_req) ? ~last_eng_q : eng_req;
  assign accept   = any_req & ((state_q == S_IDLE) | (state_q == S_RESP));
  assign in_range = addr_q < MEM_LIMIT;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    cpu_gnt          = 1'b0;
    eng_gnt          = 1'b0;
    cpu_done         = 1'b0;
    eng_done         = 1'b0;
    cpu_err          = 1'b0;
    eng_err          = 1'b0;
    mem_write_enable = 1'b0;
    busy             = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (any_req) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        busy             = 1'b1;
        cpu_gnt          = ~owner_eng_q;
        eng_gnt          = owner_eng_q;
        // Driven from the state register so reset removes it asynchronously.
        mem_write_enable = we_q & in_range;
        state_d          = S_RESP;
      end
      S_RESP: begin
        busy     = 1'b1;
        cpu_done = ~owner_eng_q;
        eng_done = owner_eng_q;
        cpu_err  = ~owner_eng_q & ~in_range;
        eng_err  = owner_eng_q & ~in_range;
        state_d  = any_req ? S_ISSUE : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_eng_q <= 1'b0;
      last_eng_q  <= 1'b1;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cpu_rd_q    <= '0;
      eng_rd_q    <= '0;
    end else begin
      if (accept) begin
        owner_eng_q <= win_eng;
        last_eng_q  <= win_eng;
        we_q        <= win_eng ? eng_we : cpu_we;
        addr_q      <= win_eng ? eng_address : cpu_address;
        wdata_q     <= win_eng ? eng_write_data : cpu_write_data;
      end
      if (state_q == S_ISSUE) begin
        if (owner_eng_q) begin
          eng_rd_q <= (!we_q && in_range) ? mem_read_data : '0;
        end else begin
          cpu_rd_q <= (!we_q && in_range) ? mem_read_data : '0;
        end
      end
    end
  end

  // The latched access only changes on acceptance, so the memory bus holds
  // its last values between accesses.
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign cpu_read_data  = cpu_rd_q;
  assign eng_read_data  = eng_rd_q;

endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: DATA_WIDTH, 32, width of every data bus.
REQ-002 Parameter: ADDR_WIDTH, 32, width of every address bus.
REQ-003 Parameter: MEM_LIMIT, 32'h80000, exclusive upper bound of valid addresses, compared unsigned.
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset, with ports as follows.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cpu_req / eng_req  in  1  access request from the processor / from the decrypt engine.
- cpu_we / eng_we  in  1  request is a write (1) or a read (0).
- cpu_address / eng_address  in  ADDR_WIDTH  request address.
- cpu_write_data / eng_write_data  in  DATA_WIDTH  write data.
- cpu_gnt / eng_gnt  out  1  request accepted; one-cycle pulse.
- cpu_done / eng_done  out  1  access complete; one-cycle pulse.
- cpu_read_data / eng_read_data  out  DATA_WIDTH  read result, valid while done is high.
- cpu_err / eng_err  out  1  out-of-range access; valid while done is high.
- mem_write_enable  out  1  data memory write enable.
- mem_address  out  ADDR_WIDTH  data memory address.
- mem_write_data  out  DATA_WIDTH  data memory write data.
- mem_read_data  in  DATA_WIDTH  data memory read data; combinational from mem_address.
- busy  out  1  state is not IDLE.

Function
REQ-005 The FSM SHALL have three states: IDLE, ISSUE and RESP.
REQ-006 In IDLE and in RESP, at a rising edge with any request high, the block SHALL arbitrate as follows.
- Latch owner, we, address and write_data of the winner.
- Go to ISSUE.
REQ-007 In IDLE with no request high, the block SHALL stay in IDLE; in RESP with no request high, it SHALL go to IDLE.
REQ-008 The winner SHALL be the only requester when one request is high; when both are high, it SHALL be the requester that is not last_owner (round-robin).
REQ-009 last_owner SHALL update to the winner at every acceptance.
REQ-010 In ISSUE, owner_gnt SHALL be 1 and all other gnt outputs SHALL be 0.
REQ-011 In ISSUE, mem_address and mem_write_data SHALL equal the latched values.
REQ-012 In ISSUE, mem_write_enable SHALL equal the latched we AND an in-range address.
REQ-013 Outside ISSUE, mem_write_enable SHALL be 0 and mem_address/mem_write_data SHALL hold their last values.
REQ-014 At the edge that ends ISSUE, the block SHALL capture the response as follows, then go to RESP unconditionally.
- If the latched access is an in-range read, capture mem_read_data into the owner's read_data.
- For a write or an out-of-range access, load 0 into the owner's read_data.
REQ-015 In RESP, owner_done SHALL be 1 for exactly one cycle; owner_err SHALL be 1 iff latched address >= MEM_LIMIT.
REQ-016 Each read_data output SHALL hold its value until that requester's next done.
REQ-017 Latency SHALL be 2 cycles from acceptance edge to done; sustained throughput SHALL be one access per 2 cycles (RESP re-arbitrates).
REQ-018 A requester SHALL hold req/we/address/write_data stable until it sees gnt.
REQ-019 req sampled in RESP SHALL be treated as a new request.
REQ-020 An out-of-range write SHALL never assert mem_write_enable.
REQ-021 Inputs sampled while in ISSUE SHALL be ignored.
REQ-022 busy SHALL be 1 in ISSUE and in RESP.

Reset
REQ-023 While rst_n is 0, the block SHALL hold the following values:
- state IDLE, last_owner = eng;
- all gnt/done/err outputs 0, read_data outputs 0;
- mem_write_enable 0, mem_address 0, mem_write_data 0, busy 0.
REQ-024 Reset asserted during ISSUE SHALL drop mem_write_enable immediately (asynchronously); no done SHALL follow.
REQ-025 After rst_n deasserts, the first contention SHALL be won by cpu.

Verification
REQ-026 CPU read: mem preloaded 0xDEADBEEF at 0x10000; cpu_req=1, we=0, addr 0x10000 -> result as follows.
- cpu_gnt in cycle 1;
- cpu_done=1, cpu_read_data=0xDEADBEEF in cycle 2;
- mem_write_enable=0 throughout.
REQ-027 Engine write: eng_req, we=1, addr 0x40000, data 0x2 -> result as follows.
- mem_write_enable=1 for exactly the ISSUE cycle, with mem_address 0x40000 and mem_write_data 0x2;
- eng_done=1, eng_read_data=0 next cycle;
- a subsequent cpu read of 0x40000 returns 0x2.
REQ-028 Contention: both req held high after reset, each dropping after its gnt -> grants in order cpu, eng; each done 2 cycles after its acceptance.
REQ-029 Out of range: cpu write to 0x80000 -> mem_write_enable never 1; cpu_done=1, cpu_err=1, cpu_read_data=0.
REQ-030 Back-to-back: cpu_req held high with writes to 0x50000 and 0x60000 -> second gnt occurs in the cycle after first done; no IDLE cycle between.
REQ-031 Reset mid-access: rst_n=0 during ISSUE of a write -> mem_write_enable falls with rst_n; no done; busy=0.
